// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block: counting mode and
// up/down direction of the shared period counter.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
    typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_e;

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: pending/active duty pair, compare against the shared
// counter, polarity inversion and the registered output.
module pwm_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             wr,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [CNT_W-1:0] cnt,
    input  logic             inv,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_pend_r;
    logic [CNT_W-1:0] duty_act_r;
    logic [CNT_W-1:0] duty_src_s;

    // A write coinciding with a load goes straight to the active register.
    assign duty_src_s = wr ? duty_in : duty_pend_r;

    // Duty shadow registers and the compare/polarity output flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_pend_r <= '0;
            duty_act_r  <= '0;
            pwm         <= 1'b0;
        end else begin
            if (wr) begin
                duty_pend_r <= duty_in;
            end
            if (load) begin
                duty_act_r <= duty_src_s;
            end
            pwm <= en ? ((cnt < duty_act_r) ^ inv) : inv;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator: one shared edge/center-aligned period counter
// with shadowed period/mode, per-channel double-buffered duty.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    center_mode,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH-1:0]       duty_wr,
    input  logic [NUM_CH*CNT_W-1:0] duty_in,
    input  logic [NUM_CH-1:0]       inv,
    output logic [NUM_CH-1:0]       PWM_sig,
    output logic                    prd_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] prd_act_r;
    cnt_dir_e         dir_r;
    cnt_dir_e         dir_nxt_s;
    pwm_mode_e        mode_act_r;
    pwm_mode_e        mode_pend_s;
    logic             wrap_s;
    logic             load_s;

    assign mode_pend_s = center_mode ? PWM_CENTER : PWM_EDGE;
    // While idle the active registers follow the pending values every cycle.
    assign load_s      = wrap_s | ~en;

    // Next count and direction; the defaults describe a wrap back to 0.
    always_comb begin
        cnt_nxt_s = '0;
        dir_nxt_s = CNT_UP;
        wrap_s    = 1'b0;
        if (!en) begin
            wrap_s = 1'b0;
        end else begin
            case (mode_act_r)
                PWM_EDGE: begin
                    if (cnt_r >= prd_act_r) begin
                        wrap_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                PWM_CENTER: begin
                    case (dir_r)
                        CNT_UP: begin
                            if (cnt_r < prd_act_r) begin
                                cnt_nxt_s = cnt_r + CNT_ONE;
                                dir_nxt_s = CNT_UP;
                            end else if (prd_act_r <= CNT_ONE) begin
                                // With P of 0 or 1 the down leg would land on 0.
                                wrap_s = 1'b1;
                            end else begin
                                cnt_nxt_s = prd_act_r - CNT_ONE;
                                dir_nxt_s = CNT_DOWN;
                            end
                        end
                        CNT_DOWN: begin
                            if (cnt_r <= CNT_ONE) begin
                                wrap_s = 1'b1;
                            end else begin
                                cnt_nxt_s = cnt_r - CNT_ONE;
                                dir_nxt_s = CNT_DOWN;
                            end
                        end
                        default: wrap_s = 1'b1;
                    endcase
                end
                default: wrap_s = 1'b1;
            endcase
        end
    end

    // Counter, direction, active period/mode and the boundary tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            dir_r      <= CNT_UP;
            prd_act_r  <= '0;
            mode_act_r <= PWM_EDGE;
            prd_done   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            dir_r    <= dir_nxt_s;
            prd_done <= wrap_s;
            if (load_s) begin
                prd_act_r  <= period;
                mode_act_r <= mode_pend_s;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .load   (load_s),
            .wr     (duty_wr[i]),
            .duty_in(duty_in[i*CNT_W +: CNT_W]),
            .cnt    (cnt_r),
            .inv    (inv[i]),
            .pwm    (PWM_sig[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random traffic,
// compared against a position-in-period reference model.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        center_mode;
    logic [7:0]  period;
    logic [3:0]  duty_wr;
    logic [31:0] duty_in;
    logic [3:0]  inv;
    logic [3:0]  PWM_sig;
    logic        prd_done;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current period plus shadow state.
    int       m_pos;
    int       m_P;
    bit       m_center;
    int       m_pend [4];
    int       m_act  [4];
    logic [3:0] m_pwm;
    logic     m_prd;

    always #5 clk = ~clk;

    pwm_multi #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .center_mode(center_mode),
        .period     (period),
        .duty_wr    (duty_wr),
        .duty_in    (duty_in),
        .inv        (inv),
        .PWM_sig    (PWM_sig),
        .prd_done   (prd_done)
    );

    function automatic int plen(int p, bit c);
        if (p == 0) return 1;
        return c ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_at(int pos, int p, bit c);
        if (c && pos > p) return 2 * p - pos;
        return pos;
    endfunction

    function automatic int m_cnt();
        return cnt_at(m_pos, m_P, m_center);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_P = 0; m_center = 0; m_pwm = 4'b0000; m_prd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
    endtask

    // Advance the model with the inputs present at the coming edge, then clock.
    task automatic tick();
        int c;
        bit b;
        int din;
        if (!en) begin
            m_pwm = inv; m_prd = 1'b0; m_pos = 0; m_P = period; m_center = center_mode;
            for (int i = 0; i < 4; i++) begin
                din = duty_in[i*8 +: 8];
                m_act[i] = duty_wr[i] ? din : m_pend[i];
                if (duty_wr[i]) m_pend[i] = din;
            end
        end else begin
            c = m_cnt();
            b = (m_pos + 1 >= plen(m_P, m_center));
            for (int i = 0; i < 4; i++) m_pwm[i] = (c < m_act[i]) ^ inv[i];
            m_prd = b;
            if (b) begin
                m_pos = 0; m_P = period; m_center = center_mode;
            end else begin
                m_pos++;
            end
            for (int i = 0; i < 4; i++) begin
                din = duty_in[i*8 +: 8];
                if (b) m_act[i] = duty_wr[i] ? din : m_pend[i];
                if (duty_wr[i]) m_pend[i] = din;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty_in = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; center_mode = 1'b0; period = 8'd0;
        duty_wr = 4'b0000; duty_in = 32'd0; inv = 4'b1111;
        model_reset();
        @(posedge clk); #1;
        checks++; if (PWM_sig !== 4'b0000) begin errors++; $display("FAIL reset_pwm: got %b exp 0000", PWM_sig); end
        checks++; if (prd_done !== 1'b0) begin errors++; $display("FAIL reset_prd: got %b exp 0", prd_done); end
        checks++; if (dut.cnt_r !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", dut.cnt_r); end
        rst_n = 1'b1;
    endtask

    task automatic test_edge_basic();
        int hi0, prd_n, bad1, bad2, hi3;
        en = 1'b0; center_mode = 1'b0; period = 8'd9; inv = 4'b1000;
        set_duty(3, 0, 10, 5); duty_wr = 4'b1111;
        tick();
        duty_wr = 4'b0000;
        tick();
        en = 1'b1;
        hi0 = 0; prd_n = 0; bad1 = 0; bad2 = 0; hi3 = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL edge_pwm: got %b exp %b", PWM_sig, m_pwm); end
            checks++; if (prd_done !== m_prd) begin errors++; $display("FAIL edge_prd: got %b exp %b", prd_done, m_prd); end
            hi0 += int'(PWM_sig[0]); prd_n += int'(prd_done);
            bad1 += int'(PWM_sig[1]); bad2 += int'(!PWM_sig[2]);
            if (k < 10 && PWM_sig[3] !== (k >= 5)) bad2++;
            hi3 += int'(PWM_sig[3]);
        end
        checks++; if (hi0 != 9) begin errors++; $display("FAIL edge_ch0_high: got %0d exp 9", hi0); end
        checks++; if (bad1 != 0 || bad2 != 0) begin errors++; $display("FAIL edge_ch1_ch2_ch3: got %0d/%0d bad exp 0/0", bad1, bad2); end
        checks++; if (hi3 != 15) begin errors++; $display("FAIL edge_ch3_high: got %0d exp 15", hi3); end
        checks++; if (prd_n != 3) begin errors++; $display("FAIL edge_prd_count: got %0d exp 3", prd_n); end
    endtask

    task automatic test_center();
        int hi0, prd_n;
        en = 1'b0; center_mode = 1'b1; period = 8'd4; inv = 4'b0000;
        set_duty(2, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6)); duty_wr = 4'b1111;
        tick();
        duty_wr = 4'b0000; en = 1'b1;
        hi0 = 0; prd_n = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL center_pwm: got %b exp %b", PWM_sig, m_pwm); end
            checks++; if (dut.cnt_r !== 8'(m_cnt())) begin errors++; $display("FAIL center_cnt: got %0d exp %0d", dut.cnt_r, m_cnt()); end
            hi0 += int'(PWM_sig[0]); prd_n += int'(prd_done);
        end
        checks++; if (hi0 != 12) begin errors++; $display("FAIL center_ch0_high: got %0d exp 12", hi0); end
        checks++; if (prd_n != 4) begin errors++; $display("FAIL center_prd_count: got %0d exp 4", prd_n); end
    endtask

    task automatic wait_cnt(input int target, input string tag);
        int n;
        n = 0;
        while (m_cnt() != target && n < 40) begin
            tick(); n++;
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL %s_pwm: got %b exp %b", tag, PWM_sig, m_pwm); end
        end
        checks++; if (dut.cnt_r !== 8'(target)) begin errors++; $display("FAIL %s_wait: cnt got %0d exp %0d", tag, dut.cnt_r, target); end
    endtask

    task automatic test_duty_shadow();
        int hi, n;
        en = 1'b0; center_mode = 1'b0; period = 8'd9; inv = 4'b0000;
        set_duty(3, 1, 1, 1); duty_wr = 4'b1111;
        tick();
        duty_wr = 4'b0000; en = 1'b1;
        wait_cnt(4, "shadow");
        set_duty(7, 1, 1, 1); duty_wr = 4'b0001;
        tick();
        duty_wr = 4'b0000;
        n = 0;
        while (!prd_done && n < 20) begin
            tick(); n++;
            checks++; if (PWM_sig[0] !== 1'b0) begin errors++; $display("FAIL shadow_midperiod: got %b exp 0", PWM_sig[0]); end
        end
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL shadow_pwm: got %b exp %b", PWM_sig, m_pwm); end
            hi += int'(PWM_sig[0]);
        end
        checks++; if (hi != 7) begin errors++; $display("FAIL shadow_new_width: got %0d exp 7", hi); end
        wait_cnt(9, "bnd");
        set_duty(2, 1, 1, 1); duty_wr = 4'b0001;
        tick();
        duty_wr = 4'b0000;
        checks++; if (prd_done !== 1'b1) begin errors++; $display("FAIL bnd_prd: got %b exp 1", prd_done); end
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            hi += int'(PWM_sig[0]);
        end
        checks++; if (hi != 2) begin errors++; $display("FAIL bnd_bypass_width: got %0d exp 2", hi); end
    endtask

    task automatic test_enable();
        int n;
        inv = 4'b0110;
        wait_cnt(6, "en");
        en = 1'b0;
        tick();
        checks++; if (PWM_sig !== 4'b0110) begin errors++; $display("FAIL en_low_pwm: got %b exp 0110", PWM_sig); end
        checks++; if (prd_done !== 1'b0) begin errors++; $display("FAIL en_low_prd: got %b exp 0", prd_done); end
        checks++; if (dut.cnt_r !== 8'd0) begin errors++; $display("FAIL en_low_cnt: got %0d exp 0", dut.cnt_r); end
        tick(); tick();
        en = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL en_rise_pwm: got %b exp %b", PWM_sig, m_pwm); end
        end while (!prd_done && n < 30);
        checks++; if (n != 10) begin errors++; $display("FAIL en_first_prd: got %0d cycles exp 10", n); end
    endtask

    task automatic test_zero_period();
        int n;
        en = 1'b0; center_mode = 1'b0; period = 8'd0; inv = 4'b0000;
        set_duty(1, 1, 1, 1); duty_wr = 4'b1111;
        tick();
        duty_wr = 4'b0000; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (prd_done !== 1'b1) begin errors++; $display("FAIL p0_prd: got %b exp 1", prd_done); end
            checks++; if (PWM_sig !== 4'b1111) begin errors++; $display("FAIL p0_pwm: got %b exp 1111", PWM_sig); end
            checks++; if (dut.cnt_r !== 8'd0) begin errors++; $display("FAIL p0_cnt: got %0d exp 0", dut.cnt_r); end
        end
        period = 8'd9;
        wait_cnt(3, "p0mid");
        period = 8'd0;
        n = 0;
        do begin
            tick(); n++;
            checks++; if (dut.cnt_r !== 8'(m_cnt())) begin errors++; $display("FAIL p0mid_cnt: got %0d exp %0d", dut.cnt_r, m_cnt()); end
        end while (!prd_done && n < 30);
        checks++; if (n != 7) begin errors++; $display("FAIL p0mid_apply: got %0d cycles exp 7", n); end
        tick();
        checks++; if (prd_done !== 1'b1 || dut.cnt_r !== 8'd0) begin errors++; $display("FAIL p0mid_after: got prd %b cnt %0d exp 1/0", prd_done, dut.cnt_r); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) period = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 31) == 0) center_mode = 1'($urandom_range(0, 1));
            duty_wr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            set_duty($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) inv = 4'($urandom_range(0, 15));
            tick();
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL rand_pwm: cycle %0d got %b exp %b", k, PWM_sig, m_pwm); end
            checks++; if (prd_done !== m_prd) begin errors++; $display("FAIL rand_prd: cycle %0d got %b exp %b", k, prd_done, m_prd); end
            checks++; if (dut.cnt_r !== 8'(m_cnt())) begin errors++; $display("FAIL rand_cnt: cycle %0d got %0d exp %0d", k, dut.cnt_r, m_cnt()); end
        end
        duty_wr = 4'b0000;
    endtask

    task automatic test_reset_mid();
        en = 1'b0; center_mode = 1'b0; period = 8'd9; inv = 4'b1010;
        set_duty(8, 8, 8, 8); duty_wr = 4'b1111;
        tick();
        duty_wr = 4'b0000; en = 1'b1;
        wait_cnt(5, "rstmid");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (PWM_sig !== 4'b0000) begin errors++; $display("FAIL rstmid_pwm: got %b exp 0000", PWM_sig); end
        checks++; if (prd_done !== 1'b0) begin errors++; $display("FAIL rstmid_prd: got %b exp 0", prd_done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (dut.cnt_r !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d exp 0", dut.cnt_r); end
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++; if (PWM_sig !== m_pwm) begin errors++; $display("FAIL rstmid_pwm_after: got %b exp %b", PWM_sig, m_pwm); end
            checks++; if (prd_done !== m_prd) begin errors++; $display("FAIL rstmid_prd_after: got %b exp %b", prd_done, m_prd); end
        end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_center();
        test_duty_shadow();
        test_enable();
        test_zero_period();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
